unified_mem_arbiter: RTL and testbench

Sequential arbiter for the pipeline's single-ported unified memory. It replaces clock-phase multiplexing of fetch and data addresses with a request/acknowledge protocol. Instruction fetch (IF stage) and load/store (MEM stage) requests are granted one at a time, the configured memory latency is counted out, and each requester receives a registered acknowledge plus read data. It sits between the pipeline's fetch/memory stages and `single_memory`, and drives the stall signals the hazard logic uses to freeze PC and pipeline registers.

---
 rtl/unified_mem_arbiter_if.sv | 54 +++++
 rtl/unified_mem_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_unified_mem_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/unified_mem_arbiter_if.sv
// Bus bundle for unified_mem_arbiter: fetch port, data port, memory port
// and the stall/busy status lines. The arbiter connects through the slave
// modport. The master modport is the environment side: the pipeline
// stages plus the memory that returns read data.
interface unified_mem_arbiter_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 32
);
    // Fetch (IF stage) port
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_flush;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;

    // Load/store (MEM stage) port
    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [2:0]        d_func3;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;

    // Single-ported memory port
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [2:0]        mem_func3;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Status toward the hazard logic
    logic              if_stall;
    logic              d_stall;
    logic              busy;

    modport slave (
        input  if_req, if_addr, if_flush,
        input  d_req, d_we, d_addr, d_func3, d_wdata,
        input  mem_rdata,
        output if_ack, if_rdata, d_ack, d_rdata,
        output mem_addr, mem_we, mem_func3, mem_wdata,
        output if_stall, d_stall, busy
    );

    modport master (
        output if_req, if_addr, if_flush,
        output d_req, d_we, d_addr, d_func3, d_wdata,
        output mem_rdata,
        input  if_ack, if_rdata, d_ack, d_rdata,
        input  mem_addr, mem_we, mem_func3, mem_wdata,
        input  if_stall, d_stall, busy
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: serialises instruction-fetch and load/store accesses
// onto one single-ported memory using a request/acknowledge handshake.
// A grant latches the request onto the mem_* outputs. The arbiter counts
// out MEM_LAT cycles, captures mem_rdata and pulses a registered ack.
// Data wins ties because it belongs to the older instruction.
// Optional build macro ARB_STARVE_GUARD_EN adds a streak counter. It forces
// a fetch grant after MAX_D_STREAK consecutive data grants made while a
// fetch waits. Without the macro, data priority is strict.
// Reset is asynchronous and active-low on the port rst.
module unified_mem_arbiter #(
    parameter int ADDR_W       = 9,
    parameter int DATA_W       = 32,
    parameter int MEM_LAT      = 1,
    parameter int MAX_D_STREAK = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    unified_mem_arbiter_if.slave   bus
);

    // lat_cnt only has to hold MEM_LAT-1, which is 0..3.
    localparam int               LAT_W       = (MEM_LAT > 2) ? 2 : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD    = LAT_W'(MEM_LAT - 1);
    localparam logic [2:0]       FETCH_FUNC3 = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IF = 2'd1,
        ST_BUSY_D  = 2'd2
    } state_t;

    state_t              state_q,     state_d;
    logic [LAT_W-1:0]    lat_cnt_q,   lat_cnt_d;
    logic                kill_q,      kill_d;
    logic                if_ack_q,    if_ack_d;
    logic                d_ack_q,     d_ack_d;
    logic [DATA_W-1:0]   if_rdata_q,  if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q,   d_rdata_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic                mem_we_q,    mem_we_d;
    logic [2:0]          mem_func3_q, mem_func3_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;

    logic                is_idle;
    logic                if_eligible;
    logic                if_first;
    logic                grant_if;
    logic                grant_d;
    logic                streak_full;

    assign is_idle = (state_q == ST_IDLE);

    // A fetch cannot be granted while it is being flushed.
    assign if_eligible = bus.if_req & ~bus.if_flush;

`ifdef ARB_STARVE_GUARD_EN
    localparam int                  STREAK_W   = $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    logic [STREAK_W-1:0] streak_q, streak_d;

    assign streak_full = (streak_q == STREAK_MAX);

    // Streak counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

    // Count data grants that leave a live fetch waiting. Clear the count
    // once the fetch is served or goes away. At the cap, a waiting fetch
    // always wins, so the count cannot pass MAX_D_STREAK.
    always_comb begin
        streak_d = streak_q;
        if (is_idle) begin
            if (grant_if || !bus.if_req || bus.if_flush) begin
                streak_d = '0;
            end else if (grant_d) begin
                streak_d = streak_q + 1'b1;
            end
        end
    end
`else
    assign streak_full = 1'b0;
`endif

    // Arbitration: the fetch is served only when no data request is present,
    // or when the starvation guard has tripped.
    assign if_first = if_eligible & (~bus.d_req | streak_full);
    assign grant_if = is_idle & if_first;
    assign grant_d  = is_idle & bus.d_req & ~if_first;

    // State and registered outputs. Reset aborts any access in flight and
    // drops mem_we immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            lat_cnt_q   <= '0;
            kill_q      <= 1'b0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_func3_q <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            lat_cnt_q   <= lat_cnt_d;
            kill_q      <= kill_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_func3_q <= mem_func3_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Next-state logic: grant in IDLE, count latency in BUSY_*, and
    // capture and acknowledge on the last busy cycle.
    always_comb begin
        state_d     = state_q;
        lat_cnt_d   = lat_cnt_q;
        kill_d      = kill_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_func3_d = mem_func3_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            ST_IDLE: begin
                kill_d = 1'b0;
                if (grant_d) begin
                    state_d     = ST_BUSY_D;
                    lat_cnt_d   = LAT_LOAD;
                    mem_addr_d  = bus.d_addr;
                    mem_func3_d = bus.d_func3;
                    mem_wdata_d = bus.d_wdata;
                    // A single write strobe, in the first BUSY_D cycle only
                    mem_we_d    = bus.d_we;
                end else if (grant_if) begin
                    state_d     = ST_BUSY_IF;
                    lat_cnt_d   = LAT_LOAD;
                    mem_addr_d  = bus.if_addr;
                    mem_func3_d = FETCH_FUNC3;
                end
            end

            ST_BUSY_IF: begin
                // A flush on any busy cycle, even the last one, kills the fetch.
                if (bus.if_flush) begin
                    kill_d = 1'b1;
                end
                if (lat_cnt_q == '0) begin
                    state_d = ST_IDLE;
                    kill_d  = 1'b0;
                    if (!kill_q && !bus.if_flush) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = bus.mem_rdata;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end
            end

            ST_BUSY_D: begin
                if (lat_cnt_q == '0) begin
                    state_d   = ST_IDLE;
                    d_ack_d   = 1'b1;
                    d_rdata_d = bus.mem_rdata;
                end else begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.if_ack    = if_ack_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_func3 = mem_func3_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.if_stall  = bus.if_req & ~if_ack_q;
    assign bus.d_stall   = bus.d_req & ~d_ack_q;
    assign bus.busy      = ~is_idle;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter. It uses two instances: u_dut1
// with MEM_LAT=1 and u_dut3 with MEM_LAT=3. The bench drives inputs 1 ns
// after a rising edge and samples outputs in the same slot, so every
// sample follows the edge that produced it.
module tb_unified_mem_arbiter;

    logic clk;
    logic rst;

    int total;
    int bad;

    unified_mem_arbiter_if #(.ADDR_W(9), .DATA_W(32)) b1 ();
    unified_mem_arbiter_if #(.ADDR_W(9), .DATA_W(32)) b3 ();

    unified_mem_arbiter #(
        .ADDR_W(9), .DATA_W(32), .MEM_LAT(1), .MAX_D_STREAK(4)
    ) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    unified_mem_arbiter #(
        .ADDR_W(9), .DATA_W(32), .MEM_LAT(3), .MAX_D_STREAK(4)
    ) u_dut3 (
        .clk (clk),
        .rst (rst),
        .bus (b3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int exp_g [10];
        int n;
        int cyc;

        total = 0;
        bad   = 0;
        rst   = 1'b0;

        b1.if_req = 0; b1.if_addr = '0; b1.if_flush = 0;
        b1.d_req = 0; b1.d_we = 0; b1.d_addr = '0; b1.d_func3 = '0; b1.d_wdata = '0;
        b1.mem_rdata = '0;
        b3.if_req = 0; b3.if_addr = '0; b3.if_flush = 0;
        b3.d_req = 0; b3.d_we = 0; b3.d_addr = '0; b3.d_func3 = '0; b3.d_wdata = '0;
        b3.mem_rdata = '0;

        // ---------------- reset state ----------------
        tick(); tick();
        chk("rst_if_ack", b1.if_ack, 0);
        chk("rst_d_ack", b1.d_ack, 0);
        chk("rst_mem_addr", b1.mem_addr, 0);
        chk("rst_mem_we", b1.mem_we, 0);
        chk("rst_mem_func3", b1.mem_func3, 0);
        chk("rst_if_rdata", b1.if_rdata, 0);
        chk("rst_busy", b1.busy, 0);
        rst = 1'b1;
        tick();

        // ---------------- single fetch, MEM_LAT=1 ----------------
        b1.if_req = 1; b1.if_addr = 9'h010;
        tick();                                      // T+1
        $display("txn fetch addr=010 issued");
        chk("f1_mem_addr", b1.mem_addr, 9'h010);
        chk("f1_mem_func3", b1.mem_func3, 3'b010);
        chk("f1_busy", b1.busy, 1);
        chk("f1_if_stall", b1.if_stall, 1);
        chk("f1_if_ack_early", b1.if_ack, 0);
        b1.mem_rdata = 32'h00A00093;
        tick();                                      // T+2
        chk("f1_if_ack", b1.if_ack, 1);
        chk("f1_if_rdata", b1.if_rdata, 32'h00A00093);
        chk("f1_d_ack", b1.d_ack, 0);
        chk("f1_if_stall_ack", b1.if_stall, 0);
        b1.if_req = 0;
        tick();                                      // T+3
        chk("f1_if_ack_drop", b1.if_ack, 0);
        chk("f1_idle", b1.busy, 0);

        // ---------------- fetch and load together ----------------
        b1.if_req = 1; b1.if_addr = 9'h020;
        b1.d_req = 1; b1.d_we = 0; b1.d_addr = 9'h080; b1.d_func3 = 3'b010;
        b1.mem_rdata = 32'h11111111;
        tick();                                      // T+1
        $display("txn fetch+load both requested");
        chk("fl_mem_addr_d", b1.mem_addr, 9'h080);
        chk("fl_if_stall", b1.if_stall, 1);
        chk("fl_d_stall", b1.d_stall, 1);
        tick();                                      // T+2
        chk("fl_d_ack", b1.d_ack, 1);
        chk("fl_d_rdata", b1.d_rdata, 32'h11111111);
        chk("fl_if_ack_t2", b1.if_ack, 0);
        b1.d_req = 0;
        b1.mem_rdata = 32'h22222222;
        tick();                                      // T+3
        chk("fl_mem_addr_if", b1.mem_addr, 9'h020);
        chk("fl_func3_if", b1.mem_func3, 3'b010);
        chk("fl_d_ack_drop", b1.d_ack, 0);
        tick();                                      // T+4
        chk("fl_if_ack", b1.if_ack, 1);
        chk("fl_if_rdata", b1.if_rdata, 32'h22222222);
        b1.if_req = 0;
        tick();

        // ---------------- store, MEM_LAT=3 ----------------
        b3.d_req = 1; b3.d_we = 1; b3.d_addr = 9'h040; b3.d_func3 = 3'b010;
        b3.d_wdata = 32'hDEADBEEF;
        tick();                                      // T+1
        $display("txn store addr=040 data=DEADBEEF");
        chk("st_we_t1", b3.mem_we, 1);
        chk("st_addr", b3.mem_addr, 9'h040);
        chk("st_wdata", b3.mem_wdata, 32'hDEADBEEF);
        chk("st_ack_t1", b3.d_ack, 0);
        tick();                                      // T+2
        chk("st_we_t2", b3.mem_we, 0);
        chk("st_ack_t2", b3.d_ack, 0);
        tick();                                      // T+3
        chk("st_we_t3", b3.mem_we, 0);
        chk("st_ack_t3", b3.d_ack, 0);
        tick();                                      // T+4
        chk("st_ack_t4", b3.d_ack, 1);
        chk("st_we_t4", b3.mem_we, 0);
        b3.d_req = 0; b3.d_we = 0;
        tick();                                      // T+5
        chk("st_ack_t5", b3.d_ack, 0);

        // ---------------- flush in IDLE blocks the grant ----------------
        b1.if_req = 1; b1.if_addr = 9'h030; b1.if_flush = 1;
        b1.mem_rdata = 32'h33333333;
        tick();
        $display("txn fetch with flush held in idle");
        chk("fi_no_grant", b1.busy, 0);
        b1.if_flush = 0;
        tick();                                      // granted: T+1, final busy cycle
        chk("fk_busy", b1.busy, 1);
        chk("fk_mem_addr", b1.mem_addr, 9'h030);
        b1.if_flush = 1;
        tick();                                      // would be the ack cycle
        $display("txn fetch flushed on final busy cycle");
        chk("fk_no_ack", b1.if_ack, 0);
        chk("fk_rdata_kept", b1.if_rdata, 32'h22222222);
        chk("fk_idle", b1.busy, 0);
        b1.if_flush = 0; b1.if_addr = 9'h034; b1.mem_rdata = 32'h44444444;
        tick();
        chk("fk2_mem_addr", b1.mem_addr, 9'h034);
        tick();
        $display("txn fetch addr=034 after flush");
        chk("fk2_if_ack", b1.if_ack, 1);
        chk("fk2_if_rdata", b1.if_rdata, 32'h44444444);
        b1.if_req = 0;
        tick();

        // ---------------- reset mid BUSY_D, MEM_LAT=3 ----------------
        b3.d_req = 1; b3.d_we = 1; b3.d_addr = 9'h050; b3.d_wdata = 32'h55555555;
        tick();                                      // T+1, write strobe up
        chk("rs_we_before", b3.mem_we, 1);
        rst = 1'b0;
        #1;
        $display("txn reset asserted during store");
        chk("rs_we_async", b3.mem_we, 0);
        chk("rs_addr", b3.mem_addr, 0);
        chk("rs_wdata", b3.mem_wdata, 0);
        chk("rs_busy", b3.busy, 0);
        b3.d_req = 0; b3.d_we = 0;
        tick(); tick(); tick();
        chk("rs_no_ack", b3.d_ack, 0);
        rst = 1'b1;
        b3.d_req = 1; b3.d_addr = 9'h060; b3.mem_rdata = 32'h66666666;
        tick();                                      // T'+1
        chk("rs2_busy", b3.busy, 1);
        chk("rs2_we", b3.mem_we, 0);
        tick();
        chk("rs2_ack_t2", b3.d_ack, 0);
        tick();
        chk("rs2_ack_t3", b3.d_ack, 0);
        tick();                                      // T'+4
        $display("txn load addr=060 after reset");
        chk("rs2_ack_t4", b3.d_ack, 1);
        chk("rs2_rdata", b3.d_rdata, 32'h66666666);
        b3.d_req = 0;
        tick();

        // ---------------- continuous contention ----------------
`ifdef ARB_STARVE_GUARD_EN
        exp_g = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`else
        exp_g = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif
        b1.if_req = 1; b1.if_addr = 9'h0AA;
        b1.d_req = 1; b1.d_we = 0; b1.d_addr = 9'h0BB;
        n = 0;
        cyc = 0;
        while (n < 10 && cyc < 200) begin
            tick();
            cyc++;
            if (b1.d_ack || b1.if_ack) begin
                $display("txn contention grant %0d: %s", n, b1.if_ack ? "IF" : "D");
                chk($sformatf("grant%0d", n), {63'b0, b1.if_ack}, exp_g[n]);
                n++;
            end
        end
        chk("grant_count", n, 10);
        b1.if_req = 0; b1.d_req = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
